// File: rtl/jpeg_pipe_sequencer.sv
// Run sequencer for the 8x8 JPEG datapath: one start pulse walks NUM_BLOCKS*8 rows through
// the fixed-latency pipeline, decoding every stage's strobes, selects and addresses from one counter.
module jpeg_pipe_sequencer #(
  parameter int NUM_BLOCKS = 4096,
  parameter int ADDR_W     = 15,
  parameter int CNT_W      = 16,
  parameter int QT_OFS     = 3,
  parameter int ZZ_OFS     = 10,
  parameter int FILL_LAT   = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic              pipe_en,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_addr,
  output logic              tp1_sel,
  output logic [2:0]        qt_row,
  output logic              zz_sel,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_addr,
  output logic              rle_en,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int TOTAL = NUM_BLOCKS * 8;
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(TOTAL + FILL_LAT - 1);
  localparam logic [CNT_W-1:0] ZZ_START   = CNT_W'(ZZ_OFS);
  localparam logic [CNT_W-1:0] FILL_START = CNT_W'(FILL_LAT);
  localparam logic [CNT_W-1:0] WR_END     = CNT_W'(TOTAL + FILL_LAT);
  localparam logic [3:0]       ZZ_OFS4    = 4'(ZZ_OFS);

  generate
    if (TOTAL > (1 << ADDR_W)) begin : g_cfg_err
      $error("jpeg_pipe_sequencer: NUM_BLOCKS*8 rows exceed the ADDR_W address space");
    end
  endgenerate

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cyc, cyc_nxt;
  logic              paused, paused_nxt;
  logic              zz_phase;

  // Handshake: start is only looked at in IDLE; busy stays high from the cycle after start
  // through the done cycle; done is a single-cycle pulse and the next start needs one IDLE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cyc    <= '0;
      paused <= 1'b0;
    end else begin
      state  <= state_nxt;
      cyc    <= cyc_nxt;
      paused <= paused_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cyc_nxt    = cyc;
    paused_nxt = busy & pause;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cyc_nxt   = '0;
        end
      end
      RUN: begin
        if (!paused) begin
          cyc_nxt = cyc + CNT_W'(1);
          if (cyc == RUN_LAST) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!paused) begin
          if (cyc == DRAIN_LAST) begin
            state_nxt = IDLE;
            cyc_nxt   = '0;
          end else begin
            cyc_nxt = cyc + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit 3 of (cyc - ZZ_OFS) without a wide subtractor: operand bit-3 XOR plus the borrow out of bits 2:0.
  assign zz_phase = cyc[3] ^ ZZ_OFS4[3] ^ (cyc[2:0] < ZZ_OFS4[2:0]);

  assign busy      = (state != IDLE);
  assign done      = (state == DRAIN) & ~paused & (cyc == DRAIN_LAST);
  assign pipe_en   = busy & ~paused;
  assign in_rd_en  = (state == RUN) & ~paused;
  assign in_addr   = busy ? cyc[ADDR_W-1:0] : '0;
  assign tp1_sel   = busy & ~cyc[3];
  assign qt_row    = busy ? (cyc[2:0] - 3'(QT_OFS)) : 3'd0;
  assign zz_sel    = busy & (cyc >= ZZ_START) & ~zz_phase;
  assign out_wr_en = busy & ~paused & (cyc >= FILL_START) & (cyc < WR_END);
  assign out_addr  = busy ? (cyc[ADDR_W-1:0] - ADDR_W'(FILL_LAT)) : '0;
  assign rle_en    = busy & (cyc > FILL_START);
  assign state_dbg = state;

endmodule

// File: tb/tb_jpeg_pipe_sequencer.sv
// Directed bench for jpeg_pipe_sequencer with NUM_BLOCKS=2 (16 rows, done at cyc 33).
module tb_jpeg_pipe_sequencer;

  localparam int ADDR_W = 15;

  logic              clk;
  logic              reset;
  logic              start;
  logic              pause;
  logic              busy;
  logic              done;
  logic              pipe_en;
  logic              in_rd_en;
  logic [ADDR_W-1:0] in_addr;
  logic              tp1_sel;
  logic [2:0]        qt_row;
  logic              zz_sel;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_addr;
  logic              rle_en;
  logic [1:0]        state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [ADDR_W-1:0] exp_q[$];

  typedef struct {
    int cyc;
    bit rd;
    int addr;
    bit tp1;
    int qt;
    bit qt_care;
    bit zz;
    bit wr;
    int oaddr;
    bit rle;
    bit done;
  } vec_t;

  vec_t tbl[$];

  jpeg_pipe_sequencer #(
    .NUM_BLOCKS(2), .ADDR_W(ADDR_W), .CNT_W(16),
    .QT_OFS(3), .ZZ_OFS(10), .FILL_LAT(18)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .busy(busy), .done(done), .pipe_en(pipe_en), .in_rd_en(in_rd_en),
    .in_addr(in_addr), .tp1_sel(tp1_sel), .qt_row(qt_row), .zz_sel(zz_sel),
    .out_wr_en(out_wr_en), .out_addr(out_addr), .rle_en(rle_en), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " pipe_en"}, int'(pipe_en), 0);
    chk({tag, " in_rd_en"}, int'(in_rd_en), 0);
    chk({tag, " in_addr"}, int'(in_addr), 0);
    chk({tag, " tp1_sel"}, int'(tp1_sel), 0);
    chk({tag, " qt_row"}, int'(qt_row), 0);
    chk({tag, " zz_sel"}, int'(zz_sel), 0);
    chk({tag, " out_wr_en"}, int'(out_wr_en), 0);
    chk({tag, " out_addr"}, int'(out_addr), 0);
    chk({tag, " rle_en"}, int'(rle_en), 0);
    chk({tag, " state"}, int'(state_dbg), 0);
  endtask

  // driver: start pulse from IDLE; afterwards the DUT sits at cyc 0 of RUN
  task automatic kick();
    chk("kick idle_before", int'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("kick busy", int'(busy), 1);
    chk("kick state", int'(state_dbg), 1);
  endtask

  // One whole run with scheduled pauses/starts; outputs checked every cycle against the
  // expected cyc/paused pair, writes checked in order against the scoreboard queue.
  task automatic tracked_run(input int pa_cyc, input int pa_len, input int pb_cyc,
                             input int pb_len, input int st_cyc, input bit st_on_done);
    int c = 0;
    bit p = 1'b0;
    int t = 0;
    int pa_left = 0;
    int pb_left = 0;
    bit pa_used = 1'b0;
    bit pb_used = 1'b0;
    bit fin = 1'b0;
    bit pz;
    logic [ADDR_W-1:0] exp_a;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(ADDR_W'(i));
    while (!fin && t < 200) begin
      chk($sformatf("busy c=%0d", c), int'(busy), 1);
      chk($sformatf("state c=%0d", c), int'(state_dbg), (c < 16) ? 1 : 2);
      chk($sformatf("pipe_en c=%0d", c), int'(pipe_en), int'(!p));
      chk($sformatf("in_rd_en c=%0d", c), int'(in_rd_en), int'(c < 16 && !p));
      chk($sformatf("in_addr c=%0d", c), int'(in_addr), c);
      chk($sformatf("tp1_sel c=%0d", c), int'(tp1_sel), int'(((c >> 3) & 1) == 0));
      if (c >= 3) chk($sformatf("qt_row c=%0d", c), int'(qt_row), (c - 3) % 8);
      chk($sformatf("zz_sel c=%0d", c), int'(zz_sel),
          (c >= 10) ? int'((((c - 10) >> 3) & 1) == 0) : 0);
      chk($sformatf("out_wr_en c=%0d", c), int'(out_wr_en), int'(c >= 18 && c < 34 && !p));
      chk($sformatf("rle_en c=%0d", c), int'(rle_en), int'(c > 18));
      chk($sformatf("done c=%0d", c), int'(done), int'(c == 33 && !p));
      if (out_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("extra_write", 1, 0);
        end else begin
          exp_a = exp_q.pop_front();
          chk($sformatf("wr_order c=%0d", c), int'(out_addr), int'(exp_a));
        end
      end
      if (c == 33 && !p) begin
        fin = 1'b1;
        chk("done_time", t, 33 + pa_len + pb_len);
      end
      if (!pa_used && pa_len > 0 && c == pa_cyc) begin
        pa_left = pa_len;
        pa_used = 1'b1;
      end
      if (!pb_used && pb_len > 0 && c == pb_cyc) begin
        pb_left = pb_len;
        pb_used = 1'b1;
      end
      pz = (pa_left > 0) || (pb_left > 0);
      if (pa_left > 0) pa_left--;
      if (pb_left > 0) pb_left--;
      pause = pz;
      start = ((c == st_cyc) && !p) || (fin && st_on_done);
      step();
      if (!p) c++;
      p = pz;
      t++;
    end
    pause = 1'b0;
    start = 1'b0;
    if (!fin) chk("done_timeout", 0, 1);
    chk("wr_count_left", exp_q.size(), 0);
    chk("post_done busy", int'(busy), 0);
    chk("post_done state", int'(state_dbg), 0);
    chk("post_done out_wr_en", int'(out_wr_en), 0);
  endtask

  initial begin
    int k;
    reset = 1'b0;
    start = 1'b0;
    pause = 1'b0;

    tbl.push_back('{0,  1'b1, 0,  1'b1, 0, 1'b0, 1'b0, 1'b0, 0,  1'b0, 1'b0});
    tbl.push_back('{3,  1'b1, 3,  1'b1, 0, 1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b0});
    tbl.push_back('{7,  1'b1, 7,  1'b1, 4, 1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b0});
    tbl.push_back('{8,  1'b1, 8,  1'b0, 5, 1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b0});
    tbl.push_back('{10, 1'b1, 10, 1'b0, 7, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0});
    tbl.push_back('{11, 1'b1, 11, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0});
    tbl.push_back('{15, 1'b1, 15, 1'b0, 4, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0});
    tbl.push_back('{16, 1'b0, 16, 1'b1, 5, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0});
    tbl.push_back('{17, 1'b0, 17, 1'b1, 6, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0});
    tbl.push_back('{18, 1'b0, 18, 1'b1, 7, 1'b1, 1'b0, 1'b1, 0,  1'b0, 1'b0});
    tbl.push_back('{19, 1'b0, 19, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1,  1'b1, 1'b0});
    tbl.push_back('{25, 1'b0, 25, 1'b0, 6, 1'b1, 1'b0, 1'b1, 7,  1'b1, 1'b0});
    tbl.push_back('{26, 1'b0, 26, 1'b0, 7, 1'b1, 1'b1, 1'b1, 8,  1'b1, 1'b0});
    tbl.push_back('{32, 1'b0, 32, 1'b1, 5, 1'b1, 1'b1, 1'b1, 14, 1'b1, 1'b0});
    tbl.push_back('{33, 1'b0, 33, 1'b1, 6, 1'b1, 1'b1, 1'b1, 15, 1'b1, 1'b1});

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #3;
    reset = 1'b1;
    step();
    check_all_zero("after_release");

    // table-driven unpaused run
    kick();
    k = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      while (k < tbl[i].cyc) begin
        step();
        k++;
      end
      chk($sformatf("tbl busy c=%0d", k), int'(busy), 1);
      chk($sformatf("tbl pipe_en c=%0d", k), int'(pipe_en), 1);
      chk($sformatf("tbl in_rd_en c=%0d", k), int'(in_rd_en), int'(tbl[i].rd));
      chk($sformatf("tbl in_addr c=%0d", k), int'(in_addr), tbl[i].addr);
      chk($sformatf("tbl tp1_sel c=%0d", k), int'(tp1_sel), int'(tbl[i].tp1));
      if (tbl[i].qt_care) chk($sformatf("tbl qt_row c=%0d", k), int'(qt_row), tbl[i].qt);
      chk($sformatf("tbl zz_sel c=%0d", k), int'(zz_sel), int'(tbl[i].zz));
      chk($sformatf("tbl out_wr_en c=%0d", k), int'(out_wr_en), int'(tbl[i].wr));
      if (tbl[i].wr) chk($sformatf("tbl out_addr c=%0d", k), int'(out_addr), tbl[i].oaddr);
      chk($sformatf("tbl rle_en c=%0d", k), int'(rle_en), int'(tbl[i].rle));
      chk($sformatf("tbl done c=%0d", k), int'(done), int'(tbl[i].done));
    end
    step();
    chk("tbl end busy", int'(busy), 0);
    chk("tbl end done", int'(done), 0);
    chk("tbl end state", int'(state_dbg), 0);
    step();

    // pause for 5 cycles during RUN
    kick();
    tracked_run(6, 5, -1, 0, -1, 1'b0);
    step();

    // pause across the RUN->DRAIN boundary and inside DRAIN
    kick();
    tracked_run(14, 3, 24, 4, -1, 1'b0);
    step();

    // start while busy and on the done cycle, then start one cycle after done
    kick();
    tracked_run(-1, 0, -1, 0, 4, 1'b1);
    kick();
    tracked_run(-1, 0, -1, 0, -1, 1'b0);
    step();

    // asynchronous reset in DRAIN
    kick();
    repeat (25) step();
    chk("pre_reset in_addr", int'(in_addr), 25);
    chk("pre_reset state", int'(state_dbg), 2);
    #3;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (12) begin
      step();
      chk("reset_held done", int'(done), 0);
      chk("reset_held busy", int'(busy), 0);
    end
    #3;
    reset = 1'b1;
    step();
    kick();
    tracked_run(-1, 0, -1, 0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
